// File: rtl/reg_file.sv
// Register file: op on wr_addr (hold/load/increment/clear), tristate read port Q, always-driven display port.
// Reads are combinational (zero latency); writes and carry update on the rising clk edge. No backpressure.
// Optional macro REG_FILE_BYPASS_EN forwards this cycle's write value to Q/zero/display.
module reg_file #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       op,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] Data,
    input  logic [AW-1:0]    rd_addr,
    input  logic             output_enable,
    output logic [WIDTH-1:0] Q,
    input  logic [AW-1:0]    disp_addr,
    output logic [WIDTH-1:0] display,
    output logic             carry,
    output logic             zero
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] regs [DEPTH];
    logic             wr_en;
    logic [WIDTH-1:0] wr_val;
    logic             carry_nxt;
    logic [WIDTH-1:0] rd_val;
    logic [WIDTH-1:0] disp_val;

    // Addresses past DEPTH exist only when DEPTH is not a power of two.
    function automatic logic in_range(input logic [AW-1:0] a);
        return {{(32-AW){1'b0}}, a} < DEPTH;
    endfunction

    always_comb begin
        wr_en     = 1'b0;
        wr_val    = '0;
        carry_nxt = carry;
        if (in_range(wr_addr)) begin
            case (op)
                2'b01: begin
                    wr_en     = 1'b1;
                    wr_val    = Data;
                    carry_nxt = 1'b0;
                end
                2'b10: begin
                    wr_en     = 1'b1;
                    wr_val    = regs[wr_addr] + ONE;
                    carry_nxt = &regs[wr_addr];
                end
                2'b11: begin
                    wr_en     = 1'b1;
                    wr_val    = '0;
                    carry_nxt = 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            carry <= 1'b0;
        end else begin
            if (wr_en) begin
                regs[wr_addr] <= wr_val;
            end
            carry <= carry_nxt;
        end
    end

    always_comb begin
        rd_val   = in_range(rd_addr)   ? regs[rd_addr]   : '0;
        disp_val = in_range(disp_addr) ? regs[disp_addr] : '0;
`ifdef REG_FILE_BYPASS_EN
        // Registers are already zero while in reset, so forwarding is suppressed there.
        if (rst_n && wr_en && (wr_addr == rd_addr)) begin
            rd_val = wr_val;
        end
        if (rst_n && wr_en && (wr_addr == disp_addr)) begin
            disp_val = wr_val;
        end
`endif
    end

    assign Q       = output_enable ? rd_val : {WIDTH{1'bz}};
    assign display = disp_val;
    assign zero    = (rd_val == '0);

endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 Parameter WIDTH, default 8: bits per register, 1..32.
REQ-002 Parameter DEPTH, default 4: number of registers, 2..16.
REQ-003 Parameter AW, default $clog2(DEPTH): address width, derived and never overridden.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 op  input  2  operation on register wr_addr: 00 hold, 01 load, 10 increment, 11 clear.
REQ-007 wr_addr  input  AW  target register of op.
REQ-008 Data  input  WIDTH  load value.
REQ-009 rd_addr  input  AW  register driven onto Q.
REQ-010 output_enable  input  1  1 drives Q; 0 leaves Q high-impedance.
REQ-011 Q  output  WIDTH  tristate bus output.
REQ-012 disp_addr  input  AW  register shown on display.
REQ-013 display  output  WIDTH  always-driven view of register disp_addr, never tristated.
REQ-014 carry  output  1  registered increment-overflow flag.
REQ-015 zero  output  1  combinational: 1 when register rd_addr equals 0, independent of output_enable.

Function
REQ-016 Storage: DEPTH registers of WIDTH bits each.
REQ-017 op=01: register wr_addr <= Data at the clock edge.
REQ-018 op=10: register wr_addr <= value+1 modulo 2^WIDTH; all-ones wraps to 0.
REQ-019 op=11: register wr_addr <= 0.
REQ-020 op=00: no register changes.
REQ-021 Only register wr_addr is written in a cycle; all other registers hold.
REQ-022 carry <= 1 on an edge where op=10 and register wr_addr is all-ones; carry <= 0 on every other edge with op!=00; carry holds when op=00.
REQ-023 Q = register rd_addr when output_enable=1, else all bits Z; combinational, zero-cycle latency from rd_addr and output_enable.
REQ-024 display = register disp_addr; combinational.
REQ-025 Same-cycle write and read of one address: without bypass (REQ-030), Q, display and zero show the old value until the edge and the new value after it.
REQ-026 Address >= DEPTH (possible only when DEPTH is not a power of 2): writes are ignored, carry holds, and reads return 0 on Q (when enabled) and display, with zero=1.
REQ-027 An X or Z on op is never interpreted as a write; registers hold.

Reset
REQ-028 rst_n=0 immediately clears all registers and carry to 0, independent of clk; Q follows output_enable (0 or Z), display=0, zero=1.
REQ-029 Reset asserted mid-operation overrides any op on that edge; the first write after release occurs on the first rising edge with rst_n=1.

Configuration
REQ-030 Macro REG_FILE_BYPASS_EN: when defined, if op is 01 or 10 and wr_addr equals rd_addr (or disp_addr), Q and zero (or display) show the value to be written this cycle, combinationally; op=11 bypasses 0. When undefined, no forwarding occurs, as in REQ-025.

Verification
REQ-031 Reset, then op=01 with wr_addr=2, Data=8'hA5; next cycle rd_addr=2, output_enable=1 -> Q=8'hA5, zero=0, carry=0.
REQ-032 Load reg1=8'hFF, then op=10 on reg1 -> reg1=8'h00, carry=1, zero=1 when reading reg1; next op=10 -> reg1=8'h01, carry=0.
REQ-033 output_enable=0 with reg0=8'h3C and disp_addr=0 -> Q=8'hZZ, display=8'h3C.
REQ-034 Same cycle: op=01, wr_addr=rd_addr=3, Data=8'h77, old value 8'h10 -> before the edge Q=8'h10 without the macro and 8'h77 with REG_FILE_BYPASS_EN; after the edge Q=8'h77 in both builds.
REQ-035 Load reg0=8'h55, then assert rst_n=0 between clock edges -> display and registers go to 0 immediately; op=01 held through reset release has no effect until the first rising edge after release.
REQ-036 DEPTH=3: op=01 with wr_addr=3 -> no register changes; rd_addr=3 -> Q=0, zero=1.
